// File: rtl/xtea_enc.sv
// XTEA encryptor: two independent 64-bit blocks under one 128-bit key, start/ready handshake.
// Define XTEA_ENC_FAST_EN to compute one full XTEA cycle per clock instead of three phases.
module xtea_enc #(
    parameter int          WORD_SIZE  = 128,
    parameter logic [31:0] DELTA      = 32'h9E3779B9,
    parameter int          NUM_ROUNDS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic [WORD_SIZE-1:0] key,
    input  logic                 start,
    output logic                 ready,
    output logic [WORD_SIZE-1:0] data_out
);

    localparam logic [2:0] S_WAITING     = 3'd0;
    localparam logic [2:0] S_ENC_PHASE_1 = 3'd1;
    localparam logic [2:0] S_ENC_SUM     = 3'd2;
    localparam logic [2:0] S_ENC_PHASE_2 = 3'd3;
    localparam logic [2:0] S_READY       = 3'd4;

    localparam logic [6:0] LAST_COUNT = 7'(NUM_ROUNDS);

    logic [2:0]           r_state;
    logic [31:0]          r_y0, r_z0, r_y1, r_z1;
    logic [31:0]          r_k0, r_k1, r_k2, r_k3;
    logic [31:0]          r_sum;
    logic [6:0]           r_count;
    logic                 r_ready;
    logic [WORD_SIZE-1:0] r_data_out;

    logic [31:0] w_ka, w_kb;
    logic [31:0] w_sum_next;
    logic [31:0] w_y0_next, w_y1_next;
    logic [31:0] w_z0_next, w_z1_next;

    function automatic logic [31:0] f_mix(input logic [31:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

    function automatic logic [31:0] f_key(input logic [1:0] idx,
                                          input logic [31:0] k0, input logic [31:0] k1,
                                          input logic [31:0] k2, input logic [31:0] k3);
        logic [31:0] k;
        case (idx)
            2'd0:    k = k0;
            2'd1:    k = k1;
            2'd2:    k = k2;
            default: k = k3;
        endcase
        return k;
    endfunction

    always_comb begin
        w_sum_next = r_sum + DELTA;
        w_ka       = f_key(r_sum[1:0], r_k0, r_k1, r_k2, r_k3);
        w_y0_next  = r_y0 + (f_mix(r_z0) ^ (r_sum + w_ka));
        w_y1_next  = r_y1 + (f_mix(r_z1) ^ (r_sum + w_ka));
`ifdef XTEA_ENC_FAST_EN
        // Second half-cycle uses the freshly updated y and the already-advanced sum.
        w_kb       = f_key(w_sum_next[12:11], r_k0, r_k1, r_k2, r_k3);
        w_z0_next  = r_z0 + (f_mix(w_y0_next) ^ (w_sum_next + w_kb));
        w_z1_next  = r_z1 + (f_mix(w_y1_next) ^ (w_sum_next + w_kb));
`else
        w_kb       = f_key(r_sum[12:11], r_k0, r_k1, r_k2, r_k3);
        w_z0_next  = r_z0 + (f_mix(r_y0) ^ (r_sum + w_kb));
        w_z1_next  = r_z1 + (f_mix(r_y1) ^ (r_sum + w_kb));
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_WAITING;
            r_y0       <= '0;
            r_z0       <= '0;
            r_y1       <= '0;
            r_z1       <= '0;
            r_k0       <= '0;
            r_k1       <= '0;
            r_k2       <= '0;
            r_k3       <= '0;
            r_sum      <= '0;
            r_count    <= '0;
            r_ready    <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_WAITING: begin
                    r_y0    <= data_in[127:96];
                    r_z0    <= data_in[95:64];
                    r_y1    <= data_in[63:32];
                    r_z1    <= data_in[31:0];
                    r_k0    <= key[127:96];
                    r_k1    <= key[95:64];
                    r_k2    <= key[63:32];
                    r_k3    <= key[31:0];
                    r_sum   <= '0;
                    r_count <= '0;
                    if (start) begin
                        r_state <= S_ENC_PHASE_1;
                    end
                end
`ifdef XTEA_ENC_FAST_EN
                S_ENC_PHASE_1: begin
                    r_y0    <= w_y0_next;
                    r_y1    <= w_y1_next;
                    r_z0    <= w_z0_next;
                    r_z1    <= w_z1_next;
                    r_sum   <= w_sum_next;
                    r_count <= r_count + 7'd1;
                    if (r_count + 7'd1 == LAST_COUNT) begin
                        r_state <= S_READY;
                    end
                end
                S_ENC_SUM, S_ENC_PHASE_2: begin
                    r_state <= S_WAITING;
                end
`else
                S_ENC_PHASE_1: begin
                    r_y0    <= w_y0_next;
                    r_y1    <= w_y1_next;
                    r_count <= r_count + 7'd1;
                    r_state <= S_ENC_SUM;
                end
                S_ENC_SUM: begin
                    r_sum   <= w_sum_next;
                    r_state <= S_ENC_PHASE_2;
                end
                S_ENC_PHASE_2: begin
                    r_z0 <= w_z0_next;
                    r_z1 <= w_z1_next;
                    if (r_count == LAST_COUNT) begin
                        r_state <= S_READY;
                    end else begin
                        r_state <= S_ENC_PHASE_1;
                    end
                end
`endif
                S_READY: begin
                    r_data_out <= {r_y0, r_z0, r_y1, r_z1};
                    r_ready    <= 1'b1;
                    r_state    <= S_WAITING;
                end
                default: begin
                    r_state <= S_WAITING;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_xtea_enc.sv
// Scoreboard bench for xtea_enc: stimulus pushes reference ciphertext and expected ready edge,
// a monitor pops and compares on every ready pulse.
module tb_xtea_enc;

    localparam int          NR  = 32;
    localparam logic [31:0] DLT = 32'h9E3779B9;
`ifdef XTEA_ENC_FAST_EN
    localparam int LAT = NR + 1;
`else
    localparam int LAT = 3 * NR + 1;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] data_in;
    logic [127:0] key;
    logic         ready;
    logic [127:0] data_out;

    xtea_enc #(.WORD_SIZE(128), .DELTA(DLT), .NUM_ROUNDS(NR)) dut (
        .clock   (clock),
        .reset   (reset),
        .data_in (data_in),
        .key     (key),
        .start   (start),
        .ready   (ready),
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt++;

    typedef struct {
        logic [127:0] data;
        int           edge_no;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [127:0] last_exp = '0;

    function automatic logic [31:0] mix(input logic [31:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

    function automatic logic [31:0] kw(input logic [127:0] k, input logic [31:0] sel);
        logic [1:0] ix;
        ix = sel[1:0];
        return k[127 - 32*ix -: 32];
    endfunction

    function automatic logic [63:0] enc64(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = v[63:32]; z = v[31:0]; s = 32'd0;
        for (int i = 0; i < NR; i++) begin
            y = y + (mix(z) ^ (s + kw(k, s)));
            s = s + DLT;
            z = z + (mix(y) ^ (s + kw(k, s >> 11)));
        end
        return {y, z};
    endfunction

    function automatic logic [63:0] dec64(input logic [63:0] v, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = v[63:32]; z = v[31:0]; s = DLT * 32'(NR);
        for (int i = 0; i < NR; i++) begin
            z = z - (mix(y) ^ (s + kw(k, s >> 11)));
            s = s - DLT;
            y = y - (mix(z) ^ (s + kw(k, s)));
        end
        return {y, z};
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k);
        return {enc64(d[127:64], k), enc64(d[63:0], k)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: got ready=1 at edge %0d expected no pulse", edge_cnt);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ciphertext", data_out, mon_e.data);
                    chk("ready_edge", 128'(edge_cnt), 128'(mon_e.edge_no));
                    last_exp = mon_e.data;
                end
            end
        end
    end

    task automatic issue(input logic [127:0] d, input logic [127:0] k);
        exp_t e;
        @(negedge clock);
        data_in = d;
        key     = k;
        start   = 1'b1;
        e.data    = model(d, k);
        e.edge_no = edge_cnt + 1 + LAT;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clock);
            i++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic kat(input string name, input logic [127:0] d, input logic [127:0] k);
        issue(d, k);
        wait_drain(LAT + 20);
        repeat (5) @(negedge clock);
        chk({name, "_hold"}, data_out, last_exp);
        chk({name, "_roundtrip"}, {dec64(data_out[127:64], k), dec64(data_out[63:0], k)}, d);
        chk({name, "_ready_low"}, 128'(ready), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1);
    end

    localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] P1 = 128'h41424344454647480123456789ABCDEF;
    localparam logic [127:0] P2 = 128'hDEADBEEFCAFEF00D0011223344556677;
    localparam logic [127:0] K2 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    initial begin
        exp_t e;
        int   n0;
        int   i;
        reset   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        key     = '0;
        repeat (3) @(negedge clock);
        chk("reset_ready", 128'(ready), 128'(0));
        chk("reset_dout", data_out, 128'h0);
        reset = 1'b1;

        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            chk("idle_ready", 128'(ready), 128'(0));
            chk("idle_dout", data_out, 128'h0);
        end

        kat("kat_zero", 128'h0, 128'h0);
        kat("kat_key", P1, K1);

        // Extra starts and plaintext changes while busy must not disturb the latched operation.
        issue(P2, K2);
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            start   = c[0];
            data_in = {$urandom, $urandom, $urandom, $urandom};
            key     = {$urandom, $urandom, $urandom, $urandom};
        end
        start = 1'b0;
        wait_drain(LAT + 20);
        repeat (LAT + 10) @(negedge clock);
        chk("busy_hold", data_out, model(P2, K2));

        // Start held high: second operation begins on the edge right after the ready pulse.
        @(negedge clock);
        data_in = P1;
        key     = K2;
        start   = 1'b1;
        n0      = edge_cnt + 1;
        e.data    = model(P1, K2);
        e.edge_no = n0 + LAT;
        sb.push_back(e);
        e.edge_no = n0 + LAT + 1 + LAT;
        sb.push_back(e);
        i = 0;
        while (sb.size() == 2 && i < LAT + 20) begin
            @(negedge clock);
            i++;
        end
        @(negedge clock);
        start = 1'b0;
        wait_drain(LAT + 20);
        repeat (5) @(negedge clock);

        // Reset mid-operation: no pulse, outputs cleared, then a fresh encryption works.
        issue(P1, K1);
        repeat (38) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("midreset_ready", 128'(ready), 128'(0));
        chk("midreset_dout", data_out, 128'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (LAT + 20) @(negedge clock);
        chk("postreset_dout", data_out, 128'h0);
        kat("kat_after_reset", P2, K1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
